mem_access_unit: RTL and testbench

Load/store initiator that drives the shared byte-addressed, big-endian 32-bit data-memory port from the pipeline's MEM stage.
- Memory port: combinational read while memread=1; word write on the falling clk edge while memwrite=1.
- Pipeline side: valid/ready request handshake and a one-cycle done/rdata/err response.
- Supports byte, halfword and word loads, signed or unsigned.
- Byte and halfword stores are done as read-modify-write, because the memory writes only whole words.

---
 rtl/mau_pkg.sv | 70 +++++++
 rtl/mau_lane.sv | 24 ++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mau_pkg
// Brief    : Shared size encodings, FSM states and lane helpers for the
//            big-endian load/store unit.
// Revision : 1.0
// ============================================================================
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Big-endian: byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = wdata[15:0];
        else        r[31:16] = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mau_lane.sv
`default_nettype none
// ============================================================================
// Module   : mau_lane
// Brief    : Combinational lane select/extend for loads and lane merge for
//            read-modify-write stores.
// Revision : 1.0
// ============================================================================
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  assign o_load   = lane_extract(i_word, i_offset, i_size, i_unsigned);
  assign o_merged = lane_merge(i_word, i_offset, i_size, i_wdata);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator for a word-wide, big-endian data
//            memory; sub-word stores go through read-modify-write.
// Revision : 1.0
// ============================================================================
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEMBYTES  = 1024,
  parameter logic [31:0] RESETADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqvalid,
  output logic        reqready,
  input  logic        reqwrite,
  input  logic [1:0]  reqsize,
  input  logic        requnsigned,
  input  logic [31:0] reqaddr,
  input  logic [31:0] reqwdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] dataaddress,
  output logic [31:0] writedata,
  input  logic [31:0] data
);

  localparam logic [32:0] c_MEMEND = 33'(MEMBYTES);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_wword;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_daddr;

  logic [2:0]  w_bytes;
  logic [32:0] w_end;
  logic        w_req_err;
  logic [31:0] w_addr_src;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  always_comb begin
    case (reqsize)
      SZ_BYTE: w_bytes = 3'd1;
      SZ_HALF: w_bytes = 3'd2;
      default: w_bytes = 3'd4;
    endcase
  end

  assign w_end     = {1'b0, reqaddr} + {30'b0, w_bytes};
  assign w_req_err = (reqsize == 2'b11)
                   || ((reqsize == SZ_HALF) && reqaddr[0])
                   || ((reqsize == SZ_WORD) && (reqaddr[1:0] != 2'b00))
                   || (w_end > c_MEMEND);

  // The strobe address is registered one cycle ahead, so on the accept edge
  // it must come from the request itself rather than the holding register.
  assign w_addr_src = (r_state == IDLE) ? reqaddr : r_addr;

  mau_lane u_lane (
    .i_word     (data),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (reqvalid) begin
          if (w_req_err)              w_next = RESP;
          else if (!reqwrite)         w_next = RD;
          else if (reqsize == SZ_WORD) w_next = WR;
          else                        w_next = RMW_RD;
        end
      end
      RD:      w_next = RESP;
      RMW_RD:  w_next = WR;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_wword    <= 32'h0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_daddr    <= RESETADDR;
    end else begin
      r_state    <= w_next;
      r_memread  <= (w_next == RD) || (w_next == RMW_RD);
      r_memwrite <= (w_next == WR);
      if ((w_next == RD) || (w_next == RMW_RD) || (w_next == WR))
        r_daddr <= {w_addr_src[31:2], 2'b00};
      else
        r_daddr <= RESETADDR;

      case (r_state)
        IDLE: begin
          if (reqvalid) begin
            r_write <= reqwrite;
            r_size  <= reqsize;
            r_uns   <= requnsigned;
            r_addr  <= reqaddr;
            r_wdata <= reqwdata;
            r_err   <= w_req_err;
            r_rdata <= 32'h0;
            if (reqwrite && (reqsize == SZ_WORD) && !w_req_err)
              r_wword <= reqwdata;
          end
        end
        RD:      r_rdata <= w_load;
        RMW_RD:  r_wword <= w_merged;
        default: ;
      endcase
    end
  end

  assign reqready    = (r_state == IDLE);
  assign done        = (r_state == RESP);
  assign err         = done && r_err;
  assign rdata       = (done && !r_write) ? r_rdata : 32'h0;
  assign memread     = r_memread;
  assign memwrite    = r_memwrite;
  assign dataaddress = r_daddr;
  assign writedata   = r_wword;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench with a negedge-write word memory.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        reqvalid;
  logic        reqready;
  logic        reqwrite;
  logic [1:0]  reqsize;
  logic        requnsigned;
  logic [31:0] reqaddr;
  logic [31:0] reqwdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        memread;
  logic        memwrite;
  logic [31:0] dataaddress;
  logic [31:0] writedata;
  logic [31:0] data;

  logic [31:0] mem [0:255];
  logic        load_mem;
  int          n_vec;
  int          n_bad;

  mem_access_unit #(.MEMBYTES(1024), .RESETADDR(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .reqvalid    (reqvalid),
    .reqready    (reqready),
    .reqwrite    (reqwrite),
    .reqsize     (reqsize),
    .requnsigned (requnsigned),
    .reqaddr     (reqaddr),
    .reqwdata    (reqwdata),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .memread     (memread),
    .memwrite    (memwrite),
    .dataaddress (dataaddress),
    .writedata   (writedata),
    .data        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data = (dataaddress < 32'd1024) ? mem[dataaddress[9:2]] : 32'h0;

  always @(negedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_0015;
      mem[1] <= 32'h0000_0002;
      mem[2] <= 32'h0000_0085;
    end else if (memwrite) begin
      mem[dataaddress[9:2]] <= writedata;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called one time unit after a posedge with the unit idle; returns one
  // time unit after the posedge following done (unit idle again).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr,
                        output logic [31:0] wdo, output logic [31:0] wao);
    int n;
    lat = 0; rd = 32'hDEAD_BEEF; er = 1'bx; nrd = 0; nwr = 0;
    wdo = 32'h0; wao = 32'h0;
    reqwrite = w; reqsize = sz; requnsigned = u; reqaddr = a; reqwdata = wd;
    reqvalid = 1'b1;
    @(posedge clk); #1;
    reqvalid = 1'b0;
    n = 1;
    while (lat == 0 && n <= 8) begin
      if (memread) nrd++;
      if (memwrite) begin nwr++; wdo = writedata; wao = dataaddress; end
      if (done) begin lat = n; rd = rdata; er = err; end
      else begin @(posedge clk); #1; n++; end
    end
    if (lat == 0) check_vec("req_timeout", 32'(lat), 32'd1);
    @(posedge clk); #1;
  endtask

  int          lat, nrd, nwr;
  logic [31:0] rd, wdo, wao;
  logic        er;
  logic        rr [1:6];
  logic        dn [1:6];
  logic [31:0] rv [1:6];
  int          seen_done;

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; load_mem = 1'b1;
    reqvalid = 1'b0; reqwrite = 1'b0; reqsize = 2'b00; requnsigned = 1'b0;
    reqaddr = 32'h0; reqwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_reqready", {31'h0, reqready}, 32'd1);
    check_vec("rst_done", {31'h0, done}, 32'd0);
    check_vec("rst_err", {31'h0, err}, 32'd0);
    check_vec("rst_rdata", rdata, 32'h0);
    check_vec("rst_memrd_wr", {30'h0, memread, memwrite}, 32'd0);
    check_vec("rst_daddr", dataaddress, 32'h0);
    check_vec("rst_wdata", writedata, 32'h0);
    @(negedge clk); #1;
    load_mem = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lw0_lat", 32'(lat), 32'd2);
    check_vec("lw0_rdata", rd, 32'h0000_0015);
    check_vec("lw0_err", {31'h0, er}, 32'd0);
    check_vec("lw0_nwr", 32'(nwr), 32'd0);
    check_vec("lw0_nrd", 32'(nrd), 32'd1);

    do_req(1'b0, 2'b00, 1'b0, 32'd11, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lb11_s", rd, 32'hFFFF_FF85);
    do_req(1'b0, 2'b00, 1'b1, 32'd11, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lbu11", rd, 32'h0000_0085);
    do_req(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lhu10", rd, 32'h0000_0085);
    do_req(1'b0, 2'b01, 1'b0, 32'd4, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lh4_upper", rd, 32'h0000_0000);

    do_req(1'b1, 2'b00, 1'b0, 32'd9, 32'h0000_00AB, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("sb9_lat", 32'(lat), 32'd3);
    check_vec("sb9_nrd", 32'(nrd), 32'd1);
    check_vec("sb9_nwr", 32'(nwr), 32'd1);
    check_vec("sb9_wdata", wdo, 32'h00AB_0085);
    check_vec("sb9_waddr", wao, 32'd8);
    check_vec("sb9_rdata0", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lw8_after_sb", rd, 32'h00AB_0085);

    do_req(1'b1, 2'b01, 1'b0, 32'd5, 32'h0000_BEEF, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("sh5_lat", 32'(lat), 32'd1);
    check_vec("sh5_err", {31'h0, er}, 32'd1);
    check_vec("sh5_strobes", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'd1022, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lw1022_err", {31'h0, er}, 32'd1);
    check_vec("lw1022_lat", 32'(lat), 32'd1);
    check_vec("lw1022_strobes", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, 2'b00, 1'b0, 32'd1024, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lb1024_err", {31'h0, er}, 32'd1);
    do_req(1'b0, 2'b00, 1'b1, 32'd1023, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("lb1023_ok", {31'h0, er}, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("sz11_err", {31'h0, er}, 32'd1);

    // Back-to-back: word store, then a load held on reqvalid behind it.
    reqwrite = 1'b1; reqsize = 2'b10; requnsigned = 1'b0;
    reqaddr = 32'd4; reqwdata = 32'h1234_5678; reqvalid = 1'b1;
    @(posedge clk); #1;
    reqwrite = 1'b0; reqwdata = 32'h0;
    for (int n = 1; n <= 6; n++) begin
      rr[n] = reqready; dn[n] = done; rv[n] = rdata;
      if (n == 1) check_vec("b2b_wdata", writedata, 32'h1234_5678);
      if (n == 4) reqvalid = 1'b0;
      if (n < 6) begin @(posedge clk); #1; end
    end
    check_vec("b2b_rdy_c1", {31'h0, rr[1]}, 32'd0);
    check_vec("b2b_rdy_c2", {31'h0, rr[2]}, 32'd0);
    check_vec("b2b_done_c2", {31'h0, dn[2]}, 32'd1);
    check_vec("b2b_rdy_c3", {31'h0, rr[3]}, 32'd1);
    check_vec("b2b_done_c4", {31'h0, dn[4]}, 32'd0);
    check_vec("b2b_done_c5", {31'h0, dn[5]}, 32'd1);
    check_vec("b2b_rdata_c5", rv[5], 32'h1234_5678);
    check_vec("b2b_mem4", mem[1], 32'h1234_5678);

    // Reset asserted in WR before the write negedge.
    reqwrite = 1'b1; reqsize = 2'b00; reqaddr = 32'd0; reqwdata = 32'h0000_00CC;
    reqvalid = 1'b1;
    @(posedge clk); #1;
    reqvalid = 1'b0;
    @(posedge clk); #1;
    check_vec("rstwr_memwrite_pre", {31'h0, memwrite}, 32'd1);
    rst = 1'b1;
    #1;
    check_vec("rstwr_memwrite_drop", {31'h0, memwrite}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    check_vec("rstwr_mem0", mem[0], 32'h0000_0015);
    seen_done = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check_vec("rstwr_no_done", 32'(seen_done), 32'd0);
    check_vec("rstwr_reqready", {31'h0, reqready}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rd, er, nrd, nwr, wdo, wao);
    check_vec("rstwr_lw0", rd, 32'h0000_0015);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
